// File: rtl/lsu_wb_master_pkg.sv
// Shared definitions for the LSU data-memory bus master: FSM state
// encoding, LSU funct3 constants and a small address helper.
package lsu_wb_master_pkg;

    // 2-bit FSM state encoding shared with the load/store formatter
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // LSU funct3 encodings (loads and stores share the low codes)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Byte address to the word address driven on the bus
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_wb_master_if.sv
// Classic Wishbone B4 single-transfer signal bundle between the LSU bus
// master and the data-memory slave.
interface lsu_wb_master_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/lsu_wb_master_timeout_cnt.sv
// Bus-wait watchdog: counts cycles spent waiting for ack/err and flags
// when the last permitted cycle is reached. Saturates instead of wrapping.
// TIMEOUT_CYCLES must be >= 2 and fit in TIMEOUT_W bits.
module wb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    // Next count: clear on bus entry, otherwise step while waiting, hold at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/lsu_wb_master.sv
// LSU data-memory bus master: turns one formatted LSU request into a single
// Wishbone B4 classic transfer and returns raw read data plus a completion
// pulse. Misaligned requests complete without touching the bus.
module lsu_wb_master
    import lsu_wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    input  logic                  req_we_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [3:0]            req_sel_i,
    input  logic                  req_mis_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    lsu_wb_master_if.master       wb
);
    lsu_state_e  state_q;
    logic        cyc_q;
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rdata_q;

    logic        bus_start;
    logic        tmo_expired;
    logic        unused_addr_lsb;

    // Byte offset is dropped on the bus; the load formatter handles it
    assign unused_addr_lsb = ^req_addr_i[1:0];

    assign bus_start = (state_q == ST_IDLE) && req_valid_i && !req_mis_i;

    wb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (bus_start),
        .en_i      (state_q == ST_BUS),
        .expired_o (tmo_expired)
    );

    // Transfer FSM with registered bus and response outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && req_mis_i) begin
                        // Misaligned: complete immediately, no bus cycle
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rdata_q     <= '0;
                    end else if (req_valid_i) begin
                        state_q <= ST_BUS;
                        cyc_q   <= 1'b1;
                        we_q    <= req_we_i;
                        adr_q   <= word_align(req_addr_i);
                        dat_q   <= req_we_i ? req_wdata_i : 32'h0;
                        sel_q   <= req_we_i ? req_sel_i : 4'b1111;
                    end
                end
                ST_BUS: begin
                    if (wb.wbm_err_i) begin
                        // Error wins over a simultaneous ack
                        state_q     <= ST_RESP;
                        cyc_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end else if (wb.wbm_ack_i) begin
                        state_q     <= ST_RESP;
                        cyc_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= wb.wbm_dat_i;
                        end
                    end else if (tmo_expired) begin
                        // Silent slave: give up and report a fault
                        state_q     <= ST_RESP;
                        cyc_q       <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    // Requester still holds the finished op; ignore it here
                    state_q   <= ST_IDLE;
                    rsp_err_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cyc_q   <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = (state_q == ST_BUS) || ((state_q == ST_IDLE) && req_valid_i);

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rdata_q;

    assign wb.wbm_cyc_o = cyc_q;
    assign wb.wbm_stb_o = cyc_q;
    assign wb.wbm_we_o  = we_q;
    assign wb.wbm_adr_o = adr_q;
    assign wb.wbm_dat_o = dat_q;
    assign wb.wbm_sel_o = sel_q;

endmodule

// File: tb/tb_lsu_wb_master.sv
// Directed bench for lsu_wb_master with a transaction-level reference model
// and a per-cycle compare process.
module tb_lsu_wb_master;
    localparam int TMO = 8;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_BOTH = 2;
    localparam int M_NONE = 3;

    logic        clk;
    logic        rst_ni;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_sel;
    logic        req_mis;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    lsu_wb_master_if wb ();

    lsu_wb_master #(
        .TIMEOUT_CYCLES (TMO),
        .TIMEOUT_W      (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_sel_i   (req_sel),
        .req_mis_i   (req_mis),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .wb          (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_active = 0;
    int          m_start  = 0;
    int          m_len    = 0;
    bit          m_err    = 0;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    bit          m_we;
    logic [31:0] m_rdata     = 32'h0;
    logic [31:0] m_new_rdata = 32'h0;

    // ---------------- slave model ----------------
    int          slv_mode  = M_NONE;
    int          slv_waits = 0;
    logic [31:0] slv_data  = 32'h0;

    initial begin
        int wcnt;
        wcnt = 0;
        wb.wbm_ack_i = 1'b0;
        wb.wbm_err_i = 1'b0;
        wb.wbm_dat_i = 32'hFFFF_0000;
        forever begin
            @(posedge clk);
            #1;
            if (wb.wbm_cyc_o) begin
                wb.wbm_ack_i = ((slv_mode == M_ACK) || (slv_mode == M_BOTH)) && (wcnt == slv_waits);
                wb.wbm_err_i = ((slv_mode == M_ERR) || (slv_mode == M_BOTH)) && (wcnt == slv_waits);
                wb.wbm_dat_i = (wcnt == slv_waits) ? slv_data : 32'hFFFF_0000;
                wcnt++;
            end else begin
                wb.wbm_ack_i = 1'b0;
                wb.wbm_err_i = 1'b0;
                wb.wbm_dat_i = 32'hFFFF_0000;
                wcnt = 0;
            end
        end
    end

    // ---------------- monitor for literal checks ----------------
    int          cyc_cnt = 0;
    int          rsp_cnt = 0;
    int          lat     = -1;
    logic        mon_err, mon_busy_rsp, mon_we;
    logic [31:0] mon_adr, mon_dat;
    logic [3:0]  mon_sel;

    // ---------------- per-cycle compare against model ----------------
    always @(negedge clk) begin
        bit          e_cyc, e_rsp, e_busy;
        logic [31:0] e_rdata;
        e_cyc   = m_active && (cyc_n >= m_start + 1) && (cyc_n <= m_start + m_len);
        e_rsp   = m_active && (cyc_n == m_start + m_len + 1);
        e_busy  = m_active && (cyc_n >= m_start) && (cyc_n <= m_start + m_len);
        e_rdata = (m_active && (cyc_n >= m_start + m_len + 1)) ? m_new_rdata : m_rdata;
        chk("cyc", wb.wbm_cyc_o, e_cyc);
        chk("stb", wb.wbm_stb_o, e_cyc);
        chk("busy", busy, e_busy);
        chk("rsp_valid", rsp_valid, e_rsp);
        chk("rdata", rsp_rdata, e_rdata);
        if (e_cyc) begin
            chk("adr", wb.wbm_adr_o, m_adr);
            chk("dat_o", wb.wbm_dat_o, m_dat);
            chk("sel", wb.wbm_sel_o, m_sel);
            chk("we", wb.wbm_we_o, m_we);
        end
        if (e_rsp) chk("rsp_err", rsp_err, m_err);

        if (wb.wbm_cyc_o) begin
            cyc_cnt++;
            mon_adr = wb.wbm_adr_o;
            mon_dat = wb.wbm_dat_o;
            mon_sel = wb.wbm_sel_o;
            mon_we  = wb.wbm_we_o;
        end
        if (rsp_valid) begin
            rsp_cnt++;
            lat          = cyc_n - m_start;
            mon_err      = rsp_err;
            mon_busy_rsp = busy;
        end
    end

    // Caller is at posedge+1. Returns at posedge+1 of the cycle after the
    // response, with req_valid already dropped.
    task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, input bit mis, input int mode,
                          input int waits, input logic [31:0] sdata);
        m_start = cyc_n;
        if (mis)                 m_len = 0;
        else if (mode == M_NONE) m_len = TMO;
        else                     m_len = (waits + 1 < TMO) ? waits + 1 : TMO;
        m_err = !mis && (mode != M_ACK || waits + 1 > TMO);
        m_adr = {addr[31:2], 2'b00};
        m_we  = we;
        m_sel = we ? sel : 4'b1111;
        m_dat = we ? wdata : 32'h0;
        if (mis)                          m_new_rdata = 32'h0;
        else if (!we && mode == M_ACK)    m_new_rdata = sdata;
        else                              m_new_rdata = m_rdata;
        slv_mode  = mode;
        slv_waits = waits;
        slv_data  = sdata;
        cyc_cnt   = 0;
        rsp_cnt   = 0;
        lat       = -1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_sel   = sel;
        req_mis   = mis;
        req_valid = 1'b1;
        m_active  = 1;
        repeat (m_len + 2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        m_active  = 0;
        m_rdata   = m_new_rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni    = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_sel   = 4'h0;
        req_mis   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_adr", wb.wbm_adr_o, 32'h0);
        chk("rst_dat", wb.wbm_dat_o, 32'h0);
        chk("rst_sel", wb.wbm_sel_o, 32'h0);
        chk("rst_we", wb.wbm_we_o, 1'b0);
        rst_ni = 1'b1;
        idle(2);

        // Load, ack after 3 wait states
        do_req(1'b0, 32'h0000_1006, 32'h1111_2222, 4'b0001, 1'b0, M_ACK, 3, 32'hDEAD_BEEF);
        chk("ld_cyc_len", cyc_cnt, 4);
        chk("ld_latency", lat, 5);
        chk("ld_adr", mon_adr, 32'h0000_1004);
        chk("ld_sel", mon_sel, 4'b1111);
        chk("ld_dat_o", mon_dat, 32'h0);
        chk("ld_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("ld_err", mon_err, 1'b0);
        idle(1);

        // Store byte, zero-wait ack
        do_req(1'b1, 32'h0000_2003, 32'h5A5A_5A5A, 4'b1000, 1'b0, M_ACK, 0, 32'h7777_7777);
        chk("st_latency", lat, 2);
        chk("st_cyc_len", cyc_cnt, 1);
        chk("st_sel", mon_sel, 4'b1000);
        chk("st_we", mon_we, 1'b1);
        chk("st_dat_o", mon_dat, 32'h5A5A_5A5A);
        chk("st_adr", mon_adr, 32'h0000_2000);
        chk("st_rdata_kept", rsp_rdata, 32'hDEAD_BEEF);

        // Misaligned store, then a back-to-back load with no idle cycle
        do_req(1'b1, 32'h0000_3001, 32'hAAAA_BBBB, 4'b1111, 1'b1, M_ACK, 0, 32'h0);
        chk("mis_cyc_len", cyc_cnt, 0);
        chk("mis_latency", lat, 1);
        chk("mis_err", mon_err, 1'b0);
        do_req(1'b0, 32'h0000_0010, 32'h0, 4'b0000, 1'b0, M_ACK, 1, 32'hCAFE_F00D);
        chk("b2b_latency", lat, 3);
        chk("b2b_rdata", rsp_rdata, 32'hCAFE_F00D);

        // Simultaneous ack and err on a load
        do_req(1'b0, 32'h0000_0020, 32'h0, 4'b0000, 1'b0, M_BOTH, 0, 32'h1111_1111);
        chk("both_err", mon_err, 1'b1);
        chk("both_rdata_kept", rsp_rdata, 32'hCAFE_F00D);
        idle(2);

        // Silent slave: timeout
        do_req(1'b0, 32'h0000_0030, 32'h0, 4'b0000, 1'b0, M_NONE, 0, 32'h2222_2222);
        chk("tmo_cyc_len", cyc_cnt, 8);
        chk("tmo_latency", lat, 9);
        chk("tmo_err", mon_err, 1'b1);
        chk("tmo_busy_at_rsp", mon_busy_rsp, 1'b0);
        idle(1);

        // Store with bus error after 2 waits
        do_req(1'b1, 32'h0000_0044, 32'h0000_BEEF, 4'b0011, 1'b0, M_ERR, 2, 32'h0);
        chk("sterr_err", mon_err, 1'b1);
        chk("sterr_latency", lat, 4);
        idle(1);

        // Asynchronous reset in the middle of a bus cycle
        m_start   = cyc_n;
        m_len     = TMO;
        m_err     = 1;
        m_adr     = 32'h0000_0050;
        m_we      = 0;
        m_sel     = 4'b1111;
        m_dat     = 32'h0;
        m_new_rdata = m_rdata;
        slv_mode  = M_NONE;
        rsp_cnt   = 0;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0050;
        req_mis   = 1'b0;
        req_valid = 1'b1;
        m_active  = 1;
        repeat (3) @(posedge clk);
        #2;
        rst_ni    = 1'b0;
        req_valid = 1'b0;
        m_active  = 0;
        m_rdata   = 32'h0;
        #1;
        chk("rst_mid_cyc", wb.wbm_cyc_o, 1'b0);
        chk("rst_mid_stb", wb.wbm_stb_o, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_rdata", rsp_rdata, 32'h0);
        @(posedge clk);
        #2;
        rst_ni = 1'b1;
        idle(3);
        chk("rst_mid_no_rsp", rsp_cnt, 0);

        // Load after reset completes normally
        do_req(1'b0, 32'h0000_0064, 32'h0, 4'b0000, 1'b0, M_ACK, 1, 32'h1234_5678);
        chk("post_rst_rdata", rsp_rdata, 32'h1234_5678);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_err", mon_err, 1'b0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
